// File: rtl/imem_program_loader.sv
// ---------------------------------------------------------------------------
// imem_program_loader
//
// Purpose:
//   Fills the instruction memory of the 72-bit processor from a framed byte
//   stream before execution starts. A frame is a header byte H (word count is
//   H+1), then (H+1)*BYTES_PER_WORD data bytes, then one checksum byte that is
//   the XOR of all data bytes (header excluded). Bytes are packed MSB first
//   into instruction words. Each word is written to consecutive IMEM
//   addresses starting at 0. The processor is held in reset until a complete
//   image with a matching checksum has been loaded.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle pulse; starts a load from IDLE, DONE or ERROR
//   s_data       in   stream byte
//   s_valid      in   s_data valid
//   s_ready      out  loader accepts a byte (transfer = s_valid & s_ready)
//   imem_we      out  IMEM write strobe, one cycle per word
//   imem_addr    out  IMEM write address
//   imem_wdata   out  IMEM write data, held between writes
//   cpu_rst_hold out  processor reset request, low only while in DONE
//   done         out  image loaded and checksum good (level)
//   error        out  checksum mismatch (level)
// ---------------------------------------------------------------------------
module imem_program_loader #(
    parameter int INSTR_WIDTH = 72,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_rst_hold,
    output logic                   done,
    output logic                   error
);

    localparam int BYTES_PER_WORD = INSTR_WIDTH / 8;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD + 1);
    localparam int PREFIX_W       = INSTR_WIDTH - 8;

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [BCNT_W-1:0]     byte_cnt;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [7:0]            acc;
    logic                  xfer;
    logic                  last_byte;
    logic                  last_word;
    logic                  restart;

    // Only the first BYTES_PER_WORD-1 bytes of a word need storage; the final
    // byte completes the word straight from the stream into imem_wdata.
    logic [PREFIX_W-1:0]    prefix;
    logic [INSTR_WIDTH-1:0] next_word;

    // Append one stream byte to the partially assembled word (byte enters LSBs).
    function automatic logic [INSTR_WIDTH-1:0] shift_in(
        input logic [PREFIX_W-1:0] word_prefix,
        input logic [7:0]          b
    );
        return {word_prefix, b};
    endfunction

    assign s_ready   = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CHECK);
    assign imem_we   = (state == ST_WRITE);
    assign xfer      = s_valid && s_ready;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_word = (word_cnt == last_idx);
    assign restart   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign next_word = shift_in(prefix, s_data);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_HDR;
            ST_HDR:   if (xfer) next_state = ST_DATA;
            ST_DATA:  if (xfer && last_byte) next_state = ST_WRITE;
            ST_WRITE: next_state = last_word ? ST_CHECK : ST_DATA;
            ST_CHECK: if (xfer) next_state = (s_data == acc) ? ST_DONE : ST_ERROR;
            ST_DONE:  if (start) next_state = ST_HDR;
            ST_ERROR: if (start) next_state = ST_HDR;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Control, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            last_idx     <= '0;
            acc          <= '0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst_hold <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state <= next_state;
            // One cycle behind the state: releases the processor the cycle
            // after DONE is entered and re-asserts the cycle after it is left.
            cpu_rst_hold <= (state != ST_DONE);

            if (restart) begin
                byte_cnt  <= '0;
                word_cnt  <= '0;
                acc       <= '0;
                imem_addr <= '0;
                done      <= 1'b0;
                error     <= 1'b0;
            end

            if (state == ST_HDR && xfer) begin
                last_idx <= ADDR_WIDTH'(s_data);
            end

            if (state == ST_DATA && xfer) begin
                acc <= acc ^ s_data;
                if (last_byte) begin
                    byte_cnt   <= '0;
                    imem_wdata <= next_word;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end

            // Address advances only between words, so a full 2**ADDR_WIDTH
            // image ends on the top address without wrapping.
            if (state == ST_WRITE && !last_word) begin
                word_cnt  <= word_cnt + 1'b1;
                imem_addr <= imem_addr + 1'b1;
            end

            if (state == ST_CHECK && xfer) begin
                done  <= (s_data == acc);
                error <= (s_data != acc);
            end
        end
    end

    // Word assembly datapath, no reset needed
    always_ff @(posedge clk) begin
        if (state == ST_DATA && xfer) begin
            prefix <= next_word[PREFIX_W-1:0];
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [71:0] imem_wdata;
    logic        cpu_rst_hold;
    logic        done;
    logic        error;

    imem_program_loader #(.INSTR_WIDTH(72), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst_hold(cpu_rst_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_addr_q[$];
    logic [71:0] exp_data_q[$];
    logic [71:0] words[256];

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_addr_q.size() == 0) begin
                check_val("extra_we", 72'(1), 72'(0));
            end else begin
                check_val("we_addr", 72'(imem_addr), 72'(exp_addr_q.pop_front()));
                check_val("we_data", imem_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int waits, output logic first_we);
        bit first = 1'b1;
        s_data  = b;
        s_valid = 1'b1;
        waits   = 0;
        first_we = 1'b0;
        forever begin
            @(negedge clk);
            if (first) first_we = imem_we;
            first = 1'b0;
            if (s_ready) break;
            waits++;
            if (waits > 100) begin
                check_val("ready_timeout", 72'(0), 72'(1));
                break;
            end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_frame(input int h, input bit bad, input bit gap, input int abort_after);
        logic [7:0] acc = 8'h00;
        logic [7:0] b;
        logic       fwe;
        int         waits;
        int         n = 0;
        send_byte(h[7:0], waits, fwe);
        for (int w = 0; w <= h; w++) begin
            exp_addr_q.push_back(w[7:0]);
            exp_data_q.push_back(words[w]);
            for (int k = 0; k < 9; k++) begin
                if (abort_after >= 0 && n == abort_after) begin
                    void'(exp_addr_q.pop_back());
                    void'(exp_data_q.pop_back());
                    return;
                end
                b = words[w][71-8*k -: 8];
                acc = acc ^ b;
                send_byte(b, waits, fwe);
                n++;
                if (k == 0 && w > 0 && !gap) begin
                    // valid held high across WRITE: one stall cycle, strobe visible then
                    check_val("bp_stall", 72'(waits), 72'(1));
                    check_val("we_latency", 72'(fwe), 72'(1));
                end
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        send_byte(bad ? (acc ^ 8'h01) : acc, waits, fwe);
    endtask

    task automatic check_end(input string tag, input bit exp_done);
        @(negedge clk);
        @(negedge clk);
        check_val({tag, "_done"}, 72'(done), 72'(exp_done));
        check_val({tag, "_error"}, 72'(error), 72'(!exp_done));
        check_val({tag, "_hold"}, 72'(cpu_rst_hold), 72'(!exp_done));
        check_val({tag, "_ready"}, 72'(s_ready), 72'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ready"}, 72'(s_ready), 72'(0));
        check_val({tag, "_we"}, 72'(imem_we), 72'(0));
        check_val({tag, "_addr"}, 72'(imem_addr), 72'(0));
        check_val({tag, "_wdata"}, imem_wdata, 72'(0));
        check_val({tag, "_hold"}, 72'(cpu_rst_hold), 72'(1));
        check_val({tag, "_done"}, 72'(done), 72'(0));
        check_val({tag, "_error"}, 72'(error), 72'(0));
    endtask

    task automatic fill_random(input int count);
        logic [95:0] t;
        for (int i = 0; i < count; i++) begin
            t = {$urandom(), $urandom(), $urandom()};
            words[i] = t[71:0];
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1 word, known pattern
        words[0] = 72'h010203040506070809;
        pulse_start();
        send_frame(0, 1'b0, 1'b0, -1);
        check_end("one_word", 1'b1);
        check_val("one_word_wdata_hold", imem_wdata, 72'h010203040506070809);

        // 3 words, valid toggling every other cycle
        fill_random(3);
        pulse_start();
        send_frame(2, 1'b0, 1'b1, -1);
        check_end("toggle", 1'b1);

        // bad checksum then recovery
        words[0] = 72'h010203040506070809;
        pulse_start();
        send_frame(0, 1'b1, 1'b0, -1);
        check_end("bad_csum", 1'b0);
        pulse_start();
        send_frame(0, 1'b0, 1'b0, -1);
        check_end("recover", 1'b1);

        // back-to-back words with valid held high through WRITE
        fill_random(4);
        pulse_start();
        send_frame(3, 1'b0, 1'b0, -1);
        check_end("backpressure", 1'b1);

        // reset after 5 data bytes of word 1, then full reload
        fill_random(3);
        pulse_start();
        send_frame(2, 1'b0, 1'b0, 14);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midload_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        send_frame(2, 1'b0, 1'b0, -1);
        check_end("reload", 1'b1);

        // maximum image
        fill_random(256);
        pulse_start();
        send_frame(255, 1'b0, 1'b0, -1);
        check_end("max_image", 1'b1);
        check_val("max_last_addr", 72'(imem_addr), 72'(8'hFF));
        repeat (20) @(posedge clk);
        #1;
        check_val("queue_empty", 72'(exp_addr_q.size()), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
